// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seven_seg_scan_ctrl_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DATA_W = 4;

  localparam logic [SEG_W-1:0] SEG_DARK = 7'h7F;

  typedef enum logic [1:0] {
    ST_GAP    = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_COMMIT = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              blank;
    logic              blink;
  } digit_t;

  localparam digit_t DIGIT_RST = '{data: '0, blank: 1'b1, blink: 1'b0};

endpackage

// File: rtl/seven_seg_decoder_7.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module seven_seg_decoder_7
  import seven_seg_scan_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] hex,
  output logic [SEG_W-1:0]  seg_n_c
);

  always_comb begin
    seg_n_c = SEG_DARK;
    case (hex)
      4'h0: seg_n_c = 7'b1000000;
      4'h1: seg_n_c = 7'b1111001;
      4'h2: seg_n_c = 7'b0100100;
      4'h3: seg_n_c = 7'b0110000;
      4'h4: seg_n_c = 7'b0011001;
      4'h5: seg_n_c = 7'b0010010;
      4'h6: seg_n_c = 7'b0000010;
      4'h7: seg_n_c = 7'b1111000;
      4'h8: seg_n_c = 7'b0000000;
      4'h9: seg_n_c = 7'b0010000;
      4'hA: seg_n_c = 7'b0001000;
      4'hB: seg_n_c = 7'b0000011;
      4'hC: seg_n_c = 7'b1000110;
      4'hD: seg_n_c = 7'b0100001;
      4'hE: seg_n_c = 7'b0000110;
      4'hF: seg_n_c = 7'b0001110;
      default: seg_n_c = SEG_DARK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scans NUM_DIGITS digits through one shared decoder; shadow buffer is committed
// to the live buffer once per frame so game-side updates never tear.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_GAP    = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_blank,
  input  logic                  wr_blink,
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] dig_n,
  output logic                  frame_tick
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [PRE_W-1:0] GAP_LAST = PRE_W'(BLANK_GAP - 1);
  localparam logic [PRE_W-1:0] DRV_LAST = PRE_W'(SCAN_DIV - BLANK_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  scan_state_e           state_q, state_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frame_q, frame_d;
  logic                  phase_q, phase_d;
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                shadow_d [NUM_DIGITS];
  digit_t                live_q   [NUM_DIGITS];
  digit_t                live_d   [NUM_DIGITS];
  logic                  wr_ready_q, wr_ready_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [SEG_W-1:0]      seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;

  digit_t           cur_c;
  logic [SEG_W-1:0] dec_seg_c;
  logic             wr_fire_c;

  assign wr_fire_c = wr_valid & wr_ready_q;

  // Shadow write port; addresses beyond the last digit are accepted but dropped.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (wr_fire_c && (wr_addr == ADDR_W'(i))) begin
        shadow_d[i] = '{data: wr_data, blank: wr_blank, blink: wr_blink};
      end
    end
  end

  // Scan sequencer: GAP -> DRIVE -> (GAP | COMMIT).
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q + PRE_W'(1);
    idx_d        = idx_q;
    frame_d      = frame_q;
    phase_d      = phase_q;
    live_d       = live_q;
    unique case (state_q)
      ST_GAP: begin
        if (pre_q == GAP_LAST) begin
          state_d = ST_DRIVE;
          pre_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (pre_q == DRV_LAST) begin
          pre_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_GAP;
          end
        end
      end
      ST_COMMIT: begin
        pre_d   = '0;
        state_d = ST_GAP;
        live_d  = shadow_q;
        if (frame_q == FRM_LAST) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FRM_W'(1);
        end
      end
      default: begin
        state_d = ST_GAP;
        pre_d   = '0;
      end
    endcase
    wr_ready_d   = (state_d != ST_COMMIT);
    frame_tick_d = (state_d == ST_COMMIT);
  end

  always_comb begin
    cur_c = live_q[0];
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) cur_c = live_q[i];
    end
  end

  seven_seg_decoder_7 u_dec (
    .hex     (cur_c.data),
    .seg_n_c (dec_seg_c)
  );

  // Output decode; a blanked digit also drops its enable so an unwritten display is fully dark.
  always_comb begin
    seg_n_d = SEG_DARK;
    dig_n_d = '1;
    if (state_q == ST_DRIVE && !cur_c.blank) begin
      dig_n_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_n_d = (cur_c.blink & phase_q) ? SEG_DARK : dec_seg_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      pre_q        <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      phase_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        shadow_q[i] <= DIGIT_RST;
        live_q[i]   <= DIGIT_RST;
      end
      wr_ready_q   <= 1'b1;
      frame_tick_q <= 1'b0;
      seg_n_q      <= SEG_DARK;
      dig_n_q      <= '1;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      shadow_q     <= shadow_d;
      live_q       <= live_d;
      wr_ready_q   <= wr_ready_d;
      frame_tick_q <= frame_tick_d;
      seg_n_q      <= seg_n_d;
      dig_n_q      <= dig_n_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign frame_tick = frame_tick_q;
  assign seg_n      = seg_n_q;
  assign dig_n      = dig_n_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: 4-digit and 3-digit builds, short scan timing.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_valid = 1'b0, wr_ready;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_blank = 1'b0, wr_blink = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  logic       frame_tick;

  logic       w3_valid = 1'b0, w3_ready;
  logic [1:0] w3_addr = '0;
  logic [3:0] w3_data = '0;
  logic [6:0] seg3_n;
  logic [2:0] dig3_n;
  logic       tick3;

  int tests = 0;
  int fails = 0;
  int unsigned ticks_seen;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .ADDR_W(2), .SCAN_DIV(8), .BLANK_GAP(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_blank(wr_blank), .wr_blink(wr_blink), .seg_n(seg_n), .dig_n(dig_n),
    .frame_tick(frame_tick));

  seven_seg_scan_ctrl #(.NUM_DIGITS(3), .ADDR_W(2), .SCAN_DIV(8), .BLANK_GAP(2), .BLINK_FRAMES(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(w3_valid), .wr_ready(w3_ready), .wr_addr(w3_addr),
    .wr_data(w3_data), .wr_blank(1'b0), .wr_blink(1'b0), .seg_n(seg3_n), .dig_n(dig3_n),
    .frame_tick(tick3));

  // Commits completed before the current cycle; read at negedge it excludes a tick seen now.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ticks_seen <= 0;
    else if (frame_tick) ticks_seen <= ticks_seen + 1;
  end

  typedef struct {
    int         off;
    logic [3:0] dig;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for frame_tick", nm);
  endtask

  task automatic wait_tick(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_tick) return;
    end
    timeout(nm);
  endtask

  task automatic wait_tick3(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick3) return;
    end
    timeout(nm);
  endtask

  // Drives one write from a negedge and returns at the negedge after acceptance (valid left high).
  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic bl, input logic bk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_blank = bl; wr_blink = bk;
    for (int i = 0; i < 50; i++) begin
      if (wr_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    timeout("write_accept");
  endtask

  task automatic run_frame(input int first, input int last, input string tag);
    int n;
    wait_tick({tag, "_tick"});
    n = 0;
    for (int i = first; i <= last; i++) begin
      while (n < vecs[i].off) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("%s_v%0d_dig", tag, i), 32'(dig_n), 32'(vecs[i].dig));
      chk($sformatf("%s_v%0d_seg", tag, i), 32'(seg_n), 32'(vecs[i].seg));
    end
  endtask

  // Counts negedges until the next tick, flagging any lit output along the way.
  task automatic count_dark(output int n, output logic bad);
    logic got;
    n = 0; bad = 1'b0; got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (seg_n !== 7'h7F || dig_n !== 4'hF) bad = 1'b1;
      if (!frame_tick && !wr_ready) bad = 1'b1;
      if (frame_tick) got = 1'b1;
    end
  endtask

  initial begin
    int n;
    int k;
    logic bad;
    logic [6:0] exp_seg;

    vecs[0]  = '{1,  4'hF, 7'h7F};
    vecs[1]  = '{3,  4'hF, 7'h7F};
    vecs[2]  = '{4,  4'hE, 7'b0110000};
    vecs[3]  = '{9,  4'hE, 7'b0110000};
    vecs[4]  = '{10, 4'hF, 7'h7F};
    vecs[5]  = '{11, 4'hF, 7'h7F};
    vecs[6]  = '{12, 4'hD, 7'b0001000};
    vecs[7]  = '{17, 4'hD, 7'b0001000};
    vecs[8]  = '{20, 4'hF, 7'h7F};
    vecs[9]  = '{4,  4'hE, 7'b0010010};
    vecs[10] = '{9,  4'hE, 7'b0010010};
    vecs[11] = '{12, 4'hD, 7'b0001000};
    vecs[12] = '{4,  4'hE, 7'b1111001};
    vecs[13] = '{10, 4'hF, 7'h7F};
    vecs[14] = '{12, 4'hD, 7'b0100100};
    vecs[15] = '{20, 4'hB, 7'b0011001};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_dig", 32'(dig_n), 32'hF);
    chk("rst_ready", 32'(wr_ready), 32'h1);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_dig3", 32'(dig3_n), 32'h7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle display stays dark, tick every 33 clocks
    count_dark(n, bad);
    chk("t1_first_tick", 32'(n), 32'd32);
    count_dark(n, bad);
    chk("t1_period", 32'(n), 32'd33);
    chk("t1_dark", 32'(bad), 32'h0);

    // 2: digits 0 and 1 appear after the next commit
    do_write(2'd0, 4'h3, 1'b0, 1'b0);
    do_write(2'd1, 4'hA, 1'b0, 1'b0);
    wr_valid = 1'b0;
    run_frame(0, 8, "t2");

    // 3: write held through COMMIT lands a frame later
    wait_tick("t3_tick");
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'h5; wr_blank = 1'b0; wr_blink = 1'b0;
    chk("t3_ready_in_commit", 32'(wr_ready), 32'h0);
    @(negedge clk);
    chk("t3_ready_after", 32'(wr_ready), 32'h1);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_old_dig", 32'(dig_n), 32'hE);
    chk("t3_old_seg", 32'(seg_n), 32'b0110000);
    run_frame(9, 11, "t3");

    // 4: blinking digit 2 alternates every two frames
    do_write(2'd2, 4'h8, 1'b0, 1'b1);
    wr_valid = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_tick("t4_tick");
      k = int'(ticks_seen) + 1;
      exp_seg = (((k / 2) % 2) == 1) ? 7'h7F : 7'h00;
      n = 0;
      while (n < 4) begin @(negedge clk); n++; end
      chk($sformatf("t4_f%0d_seg0", f), 32'(seg_n), 32'b0010010);
      while (n < 12) begin @(negedge clk); n++; end
      chk($sformatf("t4_f%0d_seg1", f), 32'(seg_n), 32'b0001000);
      while (n < 20) begin @(negedge clk); n++; end
      chk($sformatf("t4_f%0d_dig2", f), 32'(dig_n), 32'hB);
      chk($sformatf("t4_f%0d_seg2", f), 32'(seg_n), 32'(exp_seg));
    end

    // 6: async reset mid-DRIVE darkens outputs without a clock edge
    wait_tick("t6_tick");
    repeat (6) @(negedge clk);
    chk("t6_lit_before", 32'(dig_n), 32'hE);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_seg_dark", 32'(seg_n), 32'h7F);
    chk("t6_dig_dark", 32'(dig_n), 32'hF);
    chk("t6_ready", 32'(wr_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dark(n, bad);
    chk("t6_restart_tick", 32'(n), 32'd32);
    count_dark(n, bad);
    chk("t6_blank_after", 32'(bad), 32'h0);

    // 5: 3-digit build, out-of-range address plus back-to-back writes
    wait_tick3("t5_tick0");
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      w3_valid = 1'b1;
      w3_addr  = (j == 0) ? 2'd3 : 2'(j - 1);
      w3_data  = (j == 0) ? 4'h8 : ((j == 1) ? 4'h1 : ((j == 2) ? 4'h2 : 4'h4));
      chk($sformatf("t5_ready_%0d", j), 32'(w3_ready), 32'h1);
      @(negedge clk);
    end
    w3_valid = 1'b0;
    wait_tick3("t5_tick1");
    n = 0;
    for (int i = 12; i <= 15; i++) begin
      while (n < vecs[i].off) begin @(negedge clk); n++; end
      chk($sformatf("t5_v%0d_dig", i), 32'({1'b1, dig3_n}), 32'(vecs[i].dig));
      chk($sformatf("t5_v%0d_seg", i), 32'(seg3_n), 32'(vecs[i].seg));
    end
    bad = 1'b1;
    while (n < 100 && bad) begin
      @(negedge clk);
      n++;
      if (tick3) bad = 1'b0;
    end
    chk("t5_period", 32'(n), 32'd25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
